alu_share_arbiter: RTL and testbench

Shares one ALU between two requesters, for example the sort-loop address unit and the compare unit. Each requester uses a valid/ready handshake. The block arbitrates round-robin, latches the winning operands, and decodes ALUOp/Funct into the 4-bit ALU operation code. It computes the result and returns it with the requester ID on a single response channel that has backpressure. Only one operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters with a single backpressured response channel.
// Optional feature macro: ALU_ARB_SLT_EN enables the signed set-less-than operation (ALUOp 10, Funct 0010).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_alu_op,
  input  logic [3:0]       req0_funct,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_alu_op,
  input  logic [3:0]       req1_funct,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  // Returns {err, code}; unsupported combinations fall back to ADD with err set.
  function automatic logic [4:0] decode_op(input logic [1:0] alu_op, input logic [3:0] funct);
    logic [4:0] d;
    d = {1'b0, OP_ADD};
    case (alu_op)
      2'b00: d = {1'b0, OP_ADD};
      2'b01: d = {1'b0, OP_SUB};
      2'b10: begin
        case (funct)
          4'b0000: d = {1'b0, OP_ADD};
          4'b1000: d = {1'b0, OP_SUB};
          4'b0111: d = {1'b0, OP_AND};
          4'b0110: d = {1'b0, OP_OR};
`ifdef ALU_ARB_SLT_EN
          4'b0010: d = {1'b0, OP_SLT};
`endif
          default: d = {1'b1, OP_ADD};
        endcase
      end
      default: d = {1'b1, OP_ADD};
    endcase
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0] code,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = a + b;
    case (code)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SUB:  r = a - b;
`ifdef ALU_ARB_SLT_EN
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`endif
      default: r = a + b;
    endcase
    return r;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_grant_r;
  logic             req0_ready_s;
  logic             req1_ready_s;
  logic             accept0_s;
  logic             accept1_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [1:0]       op_alu_r;
  logic [3:0]       op_funct_r;
  logic             op_id_r;
  logic [4:0]       exec_dec_s;
  logic [WIDTH-1:0] exec_result_s;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             rsp_zero_r;
  logic             rsp_err_r;

  // Grant logic: a port's ready never looks at its own valid, only at the rival and last_grant.
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if (state_r == IDLE) begin
      req0_ready_s = !req1_valid || last_grant_r;
      req1_ready_s = !req0_valid || !last_grant_r;
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
  end

  assign accept0_s = req0_valid && req0_ready_s;
  assign accept1_s = req1_valid && req1_ready_s;

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept0_s || accept1_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin history and operand capture, both only on an accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= 1'b1;
      op_a_r       <= {WIDTH{1'b0}};
      op_b_r       <= {WIDTH{1'b0}};
      op_alu_r     <= 2'b00;
      op_funct_r   <= 4'b0000;
      op_id_r      <= 1'b0;
    end else if (accept0_s) begin
      last_grant_r <= 1'b0;
      op_a_r       <= req0_a;
      op_b_r       <= req0_b;
      op_alu_r     <= req0_alu_op;
      op_funct_r   <= req0_funct;
      op_id_r      <= 1'b0;
    end else if (accept1_s) begin
      last_grant_r <= 1'b1;
      op_a_r       <= req1_a;
      op_b_r       <= req1_b;
      op_alu_r     <= req1_alu_op;
      op_funct_r   <= req1_funct;
      op_id_r      <= 1'b1;
    end
  end

  assign exec_dec_s    = decode_op(op_alu_r, op_funct_r);
  assign exec_result_s = alu_compute(exec_dec_s[3:0], op_a_r, op_b_r);

  // Response registers load on EXEC->RESP and hold until the consumer takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= op_id_r;
      rsp_result_r <= exec_result_s;
      rsp_zero_r   <= (exec_result_s == {WIDTH{1'b0}});
      rsp_err_r    <= exec_dec_s[4];
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + random scoreboard bench for alu_share_arbiter; expectations come from a bench-side ALU model.
module tb_alu_share_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_alu_op, req1_alu_op;
  logic [3:0]   req0_funct, req1_funct;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [W-1:0] rsp_result;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_alu_op(req0_alu_op), .req0_funct(req0_funct),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_alu_op(req1_alu_op), .req1_funct(req1_funct),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t sb[$];
  logic obs_ids[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic [3:0] f);
    exp_t e;
    logic [W-1:0] r;
    logic err;
    err = 1'b0;
    r = a + b;
    if (op == 2'b01) r = a - b;
    else if (op == 2'b11) err = 1'b1;
    else if (op == 2'b10) begin
      if (f == 4'b1000) r = a - b;
      else if (f == 4'b0111) r = a & b;
      else if (f == 4'b0110) r = a | b;
      else if (f == 4'b0010 && SLT_EN) r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      else if (f != 4'b0000) err = 1'b1;
    end
    e.id = id; e.res = r; e.zero = (r == {W{1'b0}}); e.err = err;
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_alu_op, req0_funct));
      if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_alu_op, req1_funct));
      if (rsp_valid && rsp_ready) begin
        chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
        obs_ids.push_back(rsp_id);
      end
    end
  end

  task automatic drive(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [3:0] f);
    if (port == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_alu_op = op; req0_funct = f;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_alu_op = op; req1_funct = f;
    end
  endtask

  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end
    chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = !busy && !rsp_valid;
    end
    chk("idle_timeout", 64'(done), 64'd1);
  endtask

  task automatic issue(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [3:0] f);
    @(posedge clk); #2;
    drive(port, a, b, op, f);
    wait_accept();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fl [6] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0010, 4'b0101};
    logic done;
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_alu_op = 2'b00; req0_funct = 4'b0000;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_alu_op = 2'b00; req1_funct = 4'b0000;

    // Reset values and first-tie arbitration
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idle_ready0", 64'(req0_ready), 64'd1);
    chk("rst_idle_ready1", 64'(req1_ready), 64'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_tie_ready0", 64'(req0_ready), 64'd1);
    chk("rst_tie_ready1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #2; reset = 1'b0;

    // Latency: port 0 SUB 5-3
    @(posedge clk); #2;
    drive(1'b0, 32'd5, 32'd3, 2'b10, 4'b1000);
    @(negedge clk);
    chk("lat_ready0", 64'(req0_ready), 64'd1);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_valid", 64'(rsp_valid), 64'd0);
    chk("lat_exec_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_n2_valid", 64'(rsp_valid), 64'd1);
    chk("lat_n2_id", 64'(rsp_id), 64'd0);
    chk("lat_n2_result", 64'(rsp_result), 64'd2);
    chk("lat_n2_zero", 64'(rsp_zero), 64'd0);
    @(negedge clk);
    chk("lat_back_idle", 64'(busy), 64'd0);
    chk("lat_valid_fell", 64'(rsp_valid), 64'd0);

    // Decode corner cases; the port-1 op leaves last_grant=1
    issue(1'b0, 32'h1234, 32'h1234, 2'b01, 4'b0000);
    issue(1'b0, 32'hC, 32'hA, 2'b10, 4'b0111);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 2'b10, 4'b0010);
    issue(1'b1, 32'd2, 32'd3, 2'b11, 4'b0000);

    // Both ports valid continuously: responses alternate starting with port 0
    obs_ids.delete();
    @(posedge clk); #2;
    drive(1'b0, 32'd1, 32'd1, 2'b00, 4'b0000);
    drive(1'b1, 32'hF0, 32'h0F, 2'b10, 4'b0110);
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk); #1;
      done = (obs_ids.size() >= 4);
    end
    @(posedge clk); #2;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("alt_count", 64'(obs_ids.size()), 64'd4);
    if (obs_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("alt_id", 64'(obs_ids[i]), 64'(i % 2));
    end

    // Backpressure: RESP held for 4 cycles with both requesters waiting
    rsp_ready = 1'b0;
    @(posedge clk); #2;
    drive(1'b0, 32'h1234, 32'h1234, 2'b01, 4'b0000);
    wait_accept();
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      done = rsp_valid;
    end
    chk("bp_rsp_seen", 64'(done), 64'd1);
    @(posedge clk); #2;
    drive(1'b0, 32'd9, 32'd9, 2'b00, 4'b0000);
    drive(1'b1, 32'd9, 32'd9, 2'b00, 4'b0000);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_result", 64'(rsp_result), 64'd0);
      chk("bp_zero", 64'(rsp_zero), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_ready0", 64'(req0_ready), 64'd0);
      chk("bp_ready1", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #2;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_exit_busy", 64'(busy), 64'd0);
    chk("bp_exit_valid", 64'(rsp_valid), 64'd0);

    // Reset during EXEC: no response, last_grant returns to 1
    @(posedge clk); #2;
    drive(1'b0, 32'd7, 32'd8, 2'b00, 4'b0000);
    @(negedge clk);
    chk("rx_ready0", 64'(req0_ready), 64'd1);
    @(posedge clk); #2;
    reset = 1'b1; req0_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rx_no_valid", 64'(rsp_valid), 64'd0);
      chk("rx_busy", 64'(busy), 64'd0);
    end
    drive(1'b0, 32'd10, 32'd4, 2'b10, 4'b1000);
    drive(1'b1, 32'd6, 32'd3, 2'b10, 4'b0111);
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("rx_grant0", 64'(req0_ready), 64'd1);
    chk("rx_grant1", 64'(req1_ready), 64'd0);
    wait_accept();
    wait_idle();

    // Random mix through the scoreboard
    for (int i = 0; i < 16; i++) begin
      issue(1'($urandom_range(1, 0)), $urandom, (i % 4 == 0) ? 32'd0 : $urandom,
            2'($urandom_range(3, 0)), fl[$urandom_range(5, 0)]);
    end

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
